// File: rtl/aes_ctr_stream.sv
// aes_ctr_stream: streaming AES-128 counter-mode engine with valid/ready on both sides.
//
// Ports:
//   clk, rst          single clock, synchronous active-high reset
//   start             load nonce/ctr_init, clear blk_count and ctr_overflow, arm input (idle only)
//   nonce, ctr_init   counter block halves, sampled on an accepted start
//   key               AES-128 key, held stable from start until busy falls
//   in_valid/in_ready input handshake; in_data block, in_last marks the message end
//   out_valid/out_ready output handshake; out_data = in_data ^ keystream, out_last follows block
//   busy              armed, blocks in flight, or output FIFO non-empty
//   ctr_overflow      sticky: a block was accepted with the counter at its maximum
//   blk_count         blocks accepted since the last start
//
// The AES pipeline has no stall, so input admission uses credits: a block is only accepted
// when the FIFO is guaranteed to have room for it when it leaves the pipeline.
// The cipher pipeline needs CORE_LAT >= 11 (one key-add stage plus ten round stages);
// any extra stages are plain delay.

module aes_ctr_stream #(
    parameter int unsigned CTR_W      = 32,
    parameter int unsigned CORE_LAT   = 21,
    parameter int unsigned FIFO_DEPTH = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [127-CTR_W:0] nonce,
    input  logic [CTR_W-1:0]   ctr_init,
    input  logic [127:0]       key,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [127:0]       in_data,
    input  logic               in_last,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [127:0]       out_data,
    output logic               out_last,
    output logic               busy,
    output logic               ctr_overflow,
    output logic [CTR_W-1:0]   blk_count
);

    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);

    // ---------------------------------------------------------------- AES helpers
    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xtime(x);
        end
        return p;
    endfunction

    // S-box as GF(2^8) inverse (a^254, which maps 0 to 0) followed by the affine transform.
    function automatic logic [7:0] sbox(input logic [7:0] a);
        logic [7:0] sq;
        logic [7:0] inv;
        sq  = a;
        inv = 8'h01;
        for (int i = 1; i < 8; i++) begin
            sq  = gmul(sq, sq);
            inv = gmul(inv, sq);
        end
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
                   ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [7:0] rcon(input int unsigned r);
        logic [7:0] rc;
        rc = 8'h01;
        for (int unsigned i = 1; i < r; i++) rc = xtime(rc);
        return rc;
    endfunction

    function automatic logic [127:0] key_next(input logic [127:0] k, input logic [7:0] rc);
        logic [31:0] t, w0, w1, w2, w3;
        t  = {sbox(k[23:16]), sbox(k[15:8]), sbox(k[7:0]), sbox(k[31:24])} ^ {rc, 24'h0};
        w0 = k[127:96] ^ t;
        w1 = k[95:64] ^ w0;
        w2 = k[63:32] ^ w1;
        w3 = k[31:0] ^ w2;
        return {w0, w1, w2, w3};
    endfunction

    // One cipher round; byte i of the state is bits [127-8i -: 8], column c is bytes 4c..4c+3.
    function automatic logic [127:0] aes_round(input logic [127:0] st, input logic [127:0] rk,
                                               input logic final_rnd);
        logic [7:0]   b  [16];
        logic [7:0]   sr [16];
        logic [7:0]   a0, a1, a2, a3;
        logic [127:0] o;
        o = '0;
        for (int i = 0; i < 16; i++) b[i] = sbox(st[127 - 8 * i -: 8]);
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) sr[r + 4 * c] = b[r + 4 * ((c + r) % 4)];
        end
        for (int c = 0; c < 4; c++) begin
            a0 = sr[4 * c];
            a1 = sr[4 * c + 1];
            a2 = sr[4 * c + 2];
            a3 = sr[4 * c + 3];
            if (final_rnd) begin
                o[127 - 32 * c -: 32] = {a0, a1, a2, a3};
            end else begin
                o[127 - 32 * c -: 32] = {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
                                         a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
                                         a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
                                         xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
            end
        end
        return o ^ rk;
    endfunction

    // ---------------------------------------------------------------- control state
    logic [127-CTR_W:0] nonce_q;
    logic [CTR_W-1:0]   ctr_q;
    logic [CTR_W-1:0]   blk_q;
    logic               armed_q;
    logic               ovf_q;
    logic [CNT_W-1:0]   inflight_q;
    logic [PTR_W:0]     wr_ptr_q;
    logic [PTR_W:0]     rd_ptr_q;
    logic [PTR_W:0]     fifo_count;

    logic start_acc;
    logic accept;
    logic wrap;
    logic exit_valid;
    logic pop;

    // ---------------------------------------------------------------- AES pipeline
    // The round key travels with its state, so each block sees exactly the key of its cycle.
    logic [127:0] st_q  [CORE_LAT];
    logic [127:0] rk_q  [10];
    logic [127:0] rk_nx [1:10];
    logic [127:0] core_out;

    always_comb begin
        for (int unsigned r = 1; r <= 10; r++) rk_nx[r] = key_next(rk_q[r-1], rcon(r));
    end

    always_ff @(posedge clk) begin
        st_q[0] <= {nonce_q, ctr_q} ^ key;
        rk_q[0] <= key;
        for (int unsigned r = 1; r <= 10; r++) begin
            st_q[r] <= aes_round(st_q[r-1], rk_nx[r], r == 10);
        end
        for (int unsigned r = 1; r < 10; r++) rk_q[r] <= rk_nx[r];
        for (int unsigned r = 11; r < CORE_LAT; r++) st_q[r] <= st_q[r-1];
    end

    assign core_out = st_q[CORE_LAT-1];

    // ---------------------------------------------------------------- delay line + FIFO
    logic [CORE_LAT-1:0] dl_valid_q;
    logic [CORE_LAT-1:0] dl_last_q;
    logic [127:0]        dl_data_q [CORE_LAT];
    logic [128:0]        fifo_mem  [FIFO_DEPTH];
    logic [128:0]        head;

    always_ff @(posedge clk) begin
        dl_data_q[0] <= in_data;
        for (int unsigned i = 1; i < CORE_LAT; i++) dl_data_q[i] <= dl_data_q[i-1];
        dl_last_q <= {dl_last_q[CORE_LAT-2:0], in_last};
        if (exit_valid) begin
            fifo_mem[wr_ptr_q[PTR_W-1:0]] <= {core_out ^ dl_data_q[CORE_LAT-1],
                                              dl_last_q[CORE_LAT-1]};
        end
    end

    // ---------------------------------------------------------------- combinational glue
    always_comb begin
        fifo_count = wr_ptr_q - rd_ptr_q;
        busy       = armed_q | (inflight_q != '0) | (fifo_count != '0);
        in_ready   = armed_q & ~ovf_q & ((32'(inflight_q) + 32'(fifo_count)) < FIFO_DEPTH);
        start_acc  = start & ~busy;
        accept     = in_valid & in_ready;
        wrap       = &ctr_q;
        exit_valid = dl_valid_q[CORE_LAT-1];
        head       = fifo_mem[rd_ptr_q[PTR_W-1:0]];
        out_valid  = (fifo_count != '0);
        out_data   = out_valid ? head[128:1] : '0;
        out_last   = out_valid & head[0];
        pop        = out_valid & out_ready;
    end

    assign ctr_overflow = ovf_q;
    assign blk_count    = blk_q;

    // ---------------------------------------------------------------- sequential control
    always_ff @(posedge clk) begin
        if (rst) begin
            nonce_q <= '0;
            ctr_q   <= '0;
            blk_q   <= '0;
            armed_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else if (start_acc) begin
            nonce_q <= nonce;
            ctr_q   <= ctr_init;
            blk_q   <= '0;
            ovf_q   <= 1'b0;
            armed_q <= 1'b1;
        end else if (accept) begin
            ctr_q <= ctr_q + CTR_W'(1);
            blk_q <= blk_q + CTR_W'(1);
            if (wrap) ovf_q <= 1'b1;
            // A wrapped stream can never take input again, so it disarms; otherwise busy
            // would stay high forever and no new start could be accepted.
            if (in_last || wrap) armed_q <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            dl_valid_q <= '0;
            inflight_q <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
        end else begin
            dl_valid_q <= {dl_valid_q[CORE_LAT-2:0], accept};
            if (accept && !exit_valid) inflight_q <= inflight_q + CNT_W'(1);
            else if (!accept && exit_valid) inflight_q <= inflight_q - CNT_W'(1);
            if (exit_valid) wr_ptr_q <= wr_ptr_q + (PTR_W + 1)'(1);
            if (pop) rd_ptr_q <= rd_ptr_q + (PTR_W + 1)'(1);
        end
    end

endmodule

// File: tb/tb_aes_ctr_stream.sv
// tb_aes_ctr_stream: directed, table-driven bench for aes_ctr_stream using the
// SP800-38A F.5.1 CTR-AES128 vectors plus back-pressure, wrap, busy-start and reset cases.

module tb_aes_ctr_stream;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [95:0]  nonce;
    logic [31:0]  ctr_init;
    logic [127:0] key;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] in_data;
    logic         in_last;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] out_data;
    logic         out_last;
    logic         busy;
    logic         ctr_overflow;
    logic [31:0]  blk_count;

    always #5 clk = ~clk;

    aes_ctr_stream #(
        .CTR_W      (32),
        .CORE_LAT   (21),
        .FIFO_DEPTH (32)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .nonce        (nonce),
        .ctr_init     (ctr_init),
        .key          (key),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_data      (in_data),
        .in_last      (in_last),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_data     (out_data),
        .out_last     (out_last),
        .busy         (busy),
        .ctr_overflow (ctr_overflow),
        .blk_count    (blk_count)
    );

    localparam logic [95:0] NONCE0 = 96'hf0f1f2f3f4f5f6f7f8f9fafb;
    localparam logic [31:0] CTR0   = 32'hfcfdfeff;

    typedef struct {
        logic [127:0] pt;
        logic [127:0] ct;
        logic         last;
    } vec_t;

    vec_t kat [4];

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int ob      = 0;   // queue index where the current phase's outputs begin

    always @(posedge clk) cyc++;

    // Output collector, plus a hold check while the output is stalled.
    logic [127:0] oq [$];
    logic         ol [$];
    int           ot [$];
    int           stab_err = 0;
    logic [127:0] held_d;
    logic         held_l;
    bit           held_v = 1'b0;

    always @(negedge clk) begin
        #1;
        if (held_v && (!out_valid || out_data !== held_d || out_last !== held_l)) stab_err++;
        held_v = out_valid && !out_ready;
        held_d = out_data;
        held_l = out_last;
        if (out_valid && out_ready) begin
            oq.push_back(out_data);
            ol.push_back(out_last);
            ot.push_back(cyc);
        end
    end

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    function automatic logic [127:0] od(input int i);
        return (ob + i < oq.size()) ? oq[ob + i] : 128'hx;
    endfunction

    function automatic logic odl(input int i);
        return (ob + i < ol.size()) ? ol[ob + i] : 1'bx;
    endfunction

    function automatic int odt(input int i);
        return (ob + i < ot.size()) ? ot[ob + i] : -1;
    endfunction

    task automatic wait_out(input int n, input int bound, input string name);
        int k = 0;
        while (oq.size() - ob < n && k < bound) begin
            @(negedge clk);
            k++;
        end
        check(name, 128'(oq.size() - ob), 128'(n));
    endtask

    task automatic do_start(input logic [95:0] n, input logic [31:0] c);
        nonce    = n;
        ctr_init = c;
        start    = 1'b1;
        in_valid = 1'b1;   // offered in the start cycle; must not be taken
        in_data  = '1;
        @(negedge clk);
        start    = 1'b0;
        in_valid = 1'b0;
    endtask

    task automatic send(input logic [127:0] d, input logic l, input int bound,
                        output bit ok, output int t);
        int n = 0;
        in_valid = 1'b1;
        in_data  = d;
        in_last  = l;
        while (!in_ready && n < bound) begin
            @(negedge clk);
            n++;
        end
        ok = in_ready;
        t  = cyc;
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_in_ready"}, 128'(in_ready), 128'(0));
        check({tag, "_out_valid"}, 128'(out_valid), 128'(0));
        check({tag, "_out_data"}, out_data, 128'(0));
        check({tag, "_out_last"}, 128'(out_last), 128'(0));
        check({tag, "_busy"}, 128'(busy), 128'(0));
        check({tag, "_ovf"}, 128'(ctr_overflow), 128'(0));
        check({tag, "_blk_count"}, 128'(blk_count), 128'(0));
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation did not complete, got timeout, want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [127:0] bp_pt [40];
        logic [127:0] bp_ct [40];
        bit           ok;
        bit           ok2;
        int           t;
        int           t0;
        int           idx;
        int           k;
        int           err;

        kat[0] = '{128'h6bc1bee22e409f96e93d7e117393172a,
                   128'h874d6191b620e3261bef6864990db6ce, 1'b0};
        kat[1] = '{128'hae2d8a571e03ac9c9eb76fac45af8e51,
                   128'h9806f66b7970fdff8617187bb9fffdff, 1'b0};
        kat[2] = '{128'h30c81c46a35ce411e5fbc1191a0a52ef,
                   128'h5ae4df3edbd5d35e5b4f09020db03eab, 1'b0};
        kat[3] = '{128'hf69f2445df4f9b17ad2b417be66c3710,
                   128'h1e031dda2fbe03d1792170a0f3009cee, 1'b1};
        for (int i = 0; i < 40; i++) begin
            bp_pt[i] = (i < 4) ? kat[i].pt : {4{32'(i) * 32'h9e3779b9}};
        end

        rst       = 1'b1;
        start     = 1'b0;
        nonce     = '0;
        ctr_init  = '0;
        key       = 128'h2b7e151628aed2a6abf7158809cf4f3c;
        in_valid  = 1'b0;
        in_data   = '0;
        in_last   = 1'b0;
        out_ready = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        check_reset_state("reset");

        // Single-block message: start timing, latency, first known answer.
        ob = oq.size();
        do_start(NONCE0, CTR0);
        check("start_in_ready", 128'(in_ready), 128'(1));
        check("start_cycle_not_accepted", 128'(blk_count), 128'(0));
        send(kat[0].pt, 1'b1, 20, ok, t0);
        check("kat1_accepted", 128'(ok), 128'(1));
        wait_out(1, 60, "kat1_count");
        check("kat1_data", od(0), kat[0].ct);
        check("kat1_last", 128'(odl(0)), 128'(1));
        check("kat1_latency", 128'(odt(0) - t0), 128'(22));
        check("kat1_busy_fall", 128'(busy), 128'(0));

        // Four-block stream with a start pulse mid-message that must be ignored.
        ob = oq.size();
        do_start(NONCE0, CTR0);
        for (int i = 0; i < 4; i++) begin
            if (i == 1) begin
                start    = 1'b1;
                nonce    = 96'h0;
                ctr_init = 32'h0;
            end
            send(kat[i].pt, kat[i].last, 20, ok, t);
            start = 1'b0;
        end
        check("kat4_blk_count", 128'(blk_count), 128'(4));
        wait_out(4, 80, "kat4_count");
        for (int i = 0; i < 4; i++) begin
            check($sformatf("kat4_data%0d", i), od(i), kat[i].ct);
            check($sformatf("kat4_last%0d", i), 128'(odl(i)), 128'(kat[i].last));
            check($sformatf("kat4_rate%0d", i), 128'(odt(i) - odt(0)), 128'(i));
        end
        check("kat4_busy_fall", 128'(busy), 128'(0));
        check("kat4_blk_count_kept", 128'(blk_count), 128'(4));

        // Decrypt: the known ciphertexts restore the plaintexts.
        ob = oq.size();
        do_start(NONCE0, CTR0);
        for (int i = 0; i < 4; i++) send(kat[i].ct, kat[i].last, 20, ok, t);
        wait_out(4, 80, "dec4_count");
        for (int i = 0; i < 4; i++) check($sformatf("dec4_data%0d", i), od(i), kat[i].pt);

        // Back-pressure: 40 blocks into a stalled output; credits stop at the FIFO depth.
        ob        = oq.size();
        err       = stab_err;
        out_ready = 1'b0;
        do_start(NONCE0, CTR0);
        idx      = 0;
        in_valid = 1'b1;
        for (int c = 0; c < 80; c++) begin
            in_data = bp_pt[idx];
            in_last = (idx == 39);
            if (in_ready) idx++;
            @(negedge clk);
        end
        check("bp_credit_limit", 128'(idx), 128'(32));
        check("bp_in_ready_low", 128'(in_ready), 128'(0));
        check("bp_out_valid", 128'(out_valid), 128'(1));
        check("bp_no_pops", 128'(oq.size() - ob), 128'(0));
        out_ready = 1'b1;
        check("bp_credit_same_cycle", 128'(in_ready), 128'(0));
        @(negedge clk);
        check("bp_credit_next_cycle", 128'(in_ready), 128'(1));
        k = 0;
        while (idx < 40 && k < 200) begin
            in_data = bp_pt[idx];
            in_last = (idx == 39);
            if (in_ready) idx++;
            @(negedge clk);
            k++;
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        check("bp_all_accepted", 128'(idx), 128'(40));
        wait_out(40, 200, "bp_count");
        repeat (5) @(negedge clk);
        check("bp_no_extra", 128'(oq.size() - ob), 128'(40));
        for (int i = 0; i < 4; i++) check($sformatf("bp_kat%0d", i), od(i), kat[i].ct);
        k = 0;
        for (int i = 0; i < 40; i++) begin
            bp_ct[i] = od(i);
            if (odl(i) !== (i == 39)) k++;
        end
        check("bp_last_flags", 128'(k), 128'(0));
        check("bp_hold_stable", 128'(stab_err - err), 128'(0));
        check("bp_busy_fall", 128'(busy), 128'(0));

        // Round trip of the back-pressured stream: order and uniqueness of every block.
        ob = oq.size();
        do_start(NONCE0, CTR0);
        for (int i = 0; i < 40; i++) send(bp_ct[i], i == 39, 40, ok, t);
        wait_out(40, 200, "rt_count");
        k = 0;
        for (int i = 0; i < 40; i++) if (od(i) !== bp_pt[i]) k++;
        check("rt_mismatches", 128'(k), 128'(0));

        // Counter wrap: fffffffe and ffffffff accepted, third block refused.
        ob = oq.size();
        do_start(NONCE0, 32'hfffffffe);
        send(bp_pt[5], 1'b0, 20, ok, t);
        check("wrap_first_ovf", 128'(ctr_overflow), 128'(0));
        send(bp_pt[6], 1'b0, 20, ok2, t);
        check("wrap_two_accepted", 128'({ok, ok2}), 128'(2'b11));
        check("wrap_ovf_set", 128'(ctr_overflow), 128'(1));
        check("wrap_in_ready_low", 128'(in_ready), 128'(0));
        send(bp_pt[7], 1'b1, 30, ok, t);
        check("wrap_third_refused", 128'(ok), 128'(0));
        check("wrap_blk_count", 128'(blk_count), 128'(2));
        wait_out(2, 60, "wrap_count");
        repeat (30) @(negedge clk);
        check("wrap_no_extra", 128'(oq.size() - ob), 128'(2));
        check("wrap_busy_fall", 128'(busy), 128'(0));
        do_start(NONCE0, CTR0);
        check("wrap_restart_ovf_clear", 128'(ctr_overflow), 128'(0));
        check("wrap_restart_in_ready", 128'(in_ready), 128'(1));
        ob = oq.size();
        send(kat[0].pt, 1'b1, 20, ok, t);
        wait_out(1, 60, "wrap_restart_count");
        check("wrap_restart_data", od(0), kat[0].ct);

        // Reset with ten blocks in flight: all dropped, then a fresh message works.
        ob = oq.size();
        do_start(NONCE0, CTR0);
        for (int i = 0; i < 10; i++) send(bp_pt[i], i == 9, 20, ok, t);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_reset_state("midrst");
        repeat (40) @(negedge clk);
        check("midrst_no_outputs", 128'(oq.size() - ob), 128'(0));
        do_start(NONCE0, CTR0);
        send(kat[0].pt, 1'b1, 20, ok, t);
        wait_out(1, 60, "midrst_fresh_count");
        check("midrst_fresh_data", od(0), kat[0].ct);
        check("midrst_fresh_blk_count", 128'(blk_count), 128'(1));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/aes_ctr_stream.md
# aes_ctr_stream

Streaming, back-pressured AES-128 CTR engine built around the pipelined `aes_128` core. It accepts a message as a sequence of 128-bit blocks on a valid/ready input and emits XORed blocks in order on a valid/ready output. Counter width, core latency and output buffering are parameters, and counter wrap is detected. Encryption and decryption are the same operation; the block sits between the host data mover and the key/nonce configuration registers.

## Interface
- `CTR_W`, 32: counter width. Nonce width is `128-CTR_W`. Range 8..64.
- `CORE_LAT`, 21: `aes_128` latency in cycles, from state/key input to `out`.
- `FIFO_DEPTH`, 32: output FIFO entries. Power of two, must be ≥ `CORE_LAT+1`.
- `clk` in 1: single clock. The core runs on `clk` directly, with no gated clock.
- `rst` in 1: reset, synchronous, active-high.
- `start` in 1: load `nonce`/`ctr_init`, clear `blk_count` and `ctr_overflow`, arm the input.
- `nonce` in `128-CTR_W`: upper bits of the counter block, sampled on accepted `start`.
- `ctr_init` in `CTR_W`: initial counter, sampled on accepted `start`.
- `key` in 128: cipher key. It must stay stable from `start` until `busy` falls.
- `in_valid` in 1, `in_ready` out 1: input handshake.
- `in_data` in 128: plaintext or ciphertext block.
- `in_last` in 1: last block of the message.
- `out_valid` out 1, `out_ready` in 1: output handshake.
- `out_data` out 128: `in_data` XOR keystream.
- `out_last` out 1: `in_last` of the same block.
- `busy` out 1: armed, or blocks in flight, or FIFO non-empty.
- `ctr_overflow` out 1: sticky flag, counter wrapped.
- `blk_count` out `CTR_W`: blocks accepted since the last `start`.

## Operation
- **Registers:** `nonce_r`, `ctr_r`, `armed`, `ctr_overflow`, `blk_count`. The core state input is `{nonce_r, ctr_r}` every cycle.
- **Start:** `start` is accepted only when `busy`=0; while busy it is ignored. On accept: `nonce_r←nonce`, `ctr_r←ctr_init`, `blk_count←0`, `ctr_overflow←0`, `armed←1`.
- **Input ready:** `in_ready = armed & ~ctr_overflow & (inflight + fifo_count < FIFO_DEPTH)`. This is a credit scheme, so the FIFO can never overflow even though the core cannot stall.
- **Accept** (`in_valid & in_ready`):
  - Push {valid=1, `in_data`, `in_last`} into a `CORE_LAT`-stage delay line aligned with the core.
  - `ctr_r←ctr_r+1` mod 2^`CTR_W`.
  - `blk_count←blk_count+1`.
  - If `in_last`, then `armed←0`.
- **Idle cycles:** the delay line shifts a valid=0 bubble. The core still computes, and its result is discarded.
- **Delay-line exit with valid=1:** write {`core_out ^ data`, `last`} into the FIFO in the same cycle the core output appears.
- **Wrap:** accepting a block with `ctr_r` = 2^`CTR_W`−1 has these effects:
  - That block is still processed normally.
  - `ctr_r` becomes 0.
  - `ctr_overflow` is set next cycle.
  - `in_ready` drops and stays low until the next accepted `start`.
- **Output FIFO:** show-ahead, with `out_valid` = non-empty. A pop occurs on `out_valid & out_ready`. Simultaneous push and pop are allowed at any occupancy, including full−1.
- **`inflight`:** a counter of valid delay-line entries, +1 on accept and −1 on exit. Width is `clog2(FIFO_DEPTH+1)`.
- **`busy`:** `busy = armed | (inflight≠0) | (fifo_count≠0)`.

## Timing
- **Reset values** (one `rst` cycle): `in_ready`=0, `out_valid`=0, `out_data`=0, `out_last`=0, `busy`=0, `ctr_overflow`=0, `blk_count`=0. `armed`, `inflight`, the delay-line valid bits and FIFO pointers are all 0.
- **Reset mid-operation:** all in-flight and buffered blocks are dropped and no output is produced for them. `rst` has priority over `start`.
- **Start timing:** `start` at cycle S gives `in_ready`=1 at earliest S+1. `in_valid` during cycle S is not accepted.
- **Latency:** a block accepted at cycle T with an empty FIFO appears on `out_valid` at T+`CORE_LAT`+1.
- **Throughput:** one block per cycle sustained while `out_ready`=1.
- **Back-pressure:** with `out_ready`=0, at most `FIFO_DEPTH` blocks are accepted; then `in_ready`=0. A pop at cycle P frees a credit, so `in_ready` can rise at P+1.
- **Ordering:** output order equals input order; `out_last` aligns with its block.
- **Output stability:** `out_data`/`out_last` are held while `out_valid & ~out_ready`.
- **Busy fall:** `busy` falls the cycle after the final pop of a last-terminated message.

## Test plan
- **Known-answer, first block:** `CTR_W`=32, key 2b7e151628aed2a6abf7158809cf4f3c, nonce f0f1f2f3f4f5f6f7f8f9fafb, `ctr_init` fcfdfeff. Plaintext 6bc1bee22e409f96e93d7e117393172a → `out_data` 874d6191b620e3261bef6864990db6ce at T+22 (`CORE_LAT`=21).
- **Known-answer, four blocks:** the same settings with SP800-38A F.5.1 blocks 1–4 back-to-back and `in_last` on block 4. Required: ciphertexts in order at 1/cycle, `out_last` only on block 4, `blk_count`=4, `busy`=0 after the final pop. Feeding those ciphertexts back restores the plaintexts.
- **Back-pressure:** hold `out_ready`=0 and stream 40 blocks. Required: `in_ready` falls after exactly 32 accepts and the FIFO never overflows. Then `out_ready`=1; all 40 blocks emerge in order with no duplicates.
- **Wrap:** set `ctr_init`=fffffffe and send 3 blocks. Required: 2 accepted (counters fffffffe, ffffffff); `ctr_overflow`=1 and `in_ready`=0 after the second; 2 outputs. A new `start` clears `ctr_overflow`.
- **Start while busy:** pulse `start` while busy. Required: it is ignored, with `nonce_r`, `ctr_r` and `blk_count` unchanged.
- **Reset mid-flight:** assert `rst` for 1 cycle with 10 blocks in flight. Required: no outputs, all reset values as above, and a subsequent message works from a fresh `start`.
